// File: rtl/conv_result_packer.sv
// Converts signed convolution results to 8-bit grey levels and packs four raster-order
// pixels per 32-bit word, writing each word to the VGA frame memory with a we/ack handshake.
module conv_result_packer #(
    parameter int IMG_W  = 512,
    parameter int IMG_H  = 480,
    parameter int ADDR_W = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_mode,
    input  logic              i_pix_valid,
    input  logic [15:0]       i_pix_data,
    output logic              o_pix_ready,
    input  logic              i_flush,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_data,
    input  logic              i_mem_ack,
    output logic              o_busy,
    output logic              o_frame_done,
    output logic [1:0]        o_state
);
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PACK  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    logic              r_mode;
    logic              r_last;
    logic              r_flush_pend;
    logic [ROW_W-1:0]  r_row;
    logic [COL_W-1:0]  r_col;
    logic [1:0]        r_lane;
    logic [31:0]       r_buf;
    logic [ADDR_W-1:0] r_word_addr;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_pix_ready;
    logic              r_mem_we;
    logic              r_busy;
    logic              r_frame_done;

    logic              w_xfer;
    logic              w_col_wrap;
    logic              w_frame_end;
    logic              w_word_full;
    logic [1:0]        w_lane_after;
    logic [16:0]       w_abs;
    logic [7:0]        w_pix;
    logic [31:0]       w_buf_next;
    logic [ADDR_W-1:0] w_word_addr;
    logic [ADDR_W-1:0] w_addr_sel;

    // Handshake: a pixel moves when i_pix_valid and o_pix_ready are both high at a rising
    // edge; a word moves when o_mem_we and i_mem_ack are both high at a rising edge.
    assign w_xfer       = (r_state == S_PACK) && r_pix_ready && i_pix_valid;
    assign w_col_wrap   = (r_col == COL_W'(IMG_W - 1));
    assign w_frame_end  = w_xfer && w_col_wrap && (r_row == ROW_W'(IMG_H - 1));
    assign w_word_full  = w_xfer && (r_lane == 2'd3);
    assign w_lane_after = w_xfer ? (r_lane + 2'd1) : r_lane;
    assign w_word_addr  = ADDR_W'({r_row, r_col[COL_W-1:2]});
    // A word's address comes from its first pixel, which may be arriving right now.
    assign w_addr_sel   = (w_xfer && (r_lane == 2'd0)) ? w_word_addr : r_word_addr;

    always_comb begin
        w_abs = i_pix_data[15] ? (17'd0 - {1'b1, i_pix_data}) : {1'b0, i_pix_data};
        w_pix = 8'd0;
        if (i_pix_data[15]) begin
            if (r_mode) w_pix = (w_abs > 17'd255) ? 8'hFF : w_abs[7:0];
        end else begin
            w_pix = (i_pix_data > 16'd255) ? 8'hFF : i_pix_data[7:0];
        end
        w_buf_next = r_buf;
        w_buf_next[{r_lane, 3'b000} +: 8] = w_pix;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_mode       <= 1'b0;
            r_last       <= 1'b0;
            r_flush_pend <= 1'b0;
            r_row        <= '0;
            r_col        <= '0;
            r_lane       <= '0;
            r_buf        <= '0;
            r_word_addr  <= '0;
            r_mem_addr   <= '0;
            r_pix_ready  <= 1'b0;
            r_mem_we     <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_frame_done <= 1'b0;
                    if (i_start) begin
                        r_mode       <= i_mode;
                        r_row        <= '0;
                        r_col        <= '0;
                        r_lane       <= '0;
                        r_buf        <= '0;
                        r_last       <= 1'b0;
                        r_flush_pend <= 1'b0;
                        r_pix_ready  <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= S_PACK;
                    end
                end
                S_PACK: begin
                    if (w_xfer) begin
                        r_buf  <= w_buf_next;
                        r_lane <= r_lane + 2'd1;
                        if (r_lane == 2'd0) r_word_addr <= w_word_addr;
                        if (w_col_wrap) begin
                            r_col <= '0;
                            r_row <= r_row + ROW_W'(1);
                        end else begin
                            r_col <= r_col + COL_W'(1);
                        end
                        if (w_frame_end) r_last <= 1'b1;
                    end
                    // A flush seen with a transfer applies after that pixel has been stored.
                    if (w_word_full || (i_flush && (w_lane_after != 2'd0))) begin
                        r_pix_ready  <= 1'b0;
                        r_mem_we     <= 1'b1;
                        r_mem_addr   <= w_addr_sel;
                        r_flush_pend <= i_flush;
                        r_state      <= S_WRITE;
                    end else if (i_flush) begin
                        r_pix_ready  <= 1'b0;
                        r_frame_done <= 1'b1;
                        r_state      <= S_DONE;
                    end
                end
                S_WRITE: begin
                    if (i_mem_ack) begin
                        r_mem_we <= 1'b0;
                        r_buf    <= '0;
                        r_lane   <= '0;
                        if (r_last || r_flush_pend) begin
                            r_frame_done <= 1'b1;
                            r_state      <= S_DONE;
                        end else begin
                            r_pix_ready <= 1'b1;
                            r_state     <= S_PACK;
                        end
                    end
                end
                S_DONE: begin
                    r_frame_done <= 1'b0;
                    r_busy       <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_pix_ready  = r_pix_ready;
    assign o_mem_we     = r_mem_we;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_data   = r_buf;
    assign o_busy       = r_busy;
    assign o_frame_done = r_frame_done;
    assign o_state      = r_state;
endmodule
